ff_checker: RTL

FF_CHECKER -- requirements
Module: ff_checker

---
 rtl/ff_checker_if.sv | 25 ++
 rtl/ff_checker.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ff_checker_if.sv
// Stimulus/response bundle between a test driver and the ff_checker self-check block.
// The driver owns start/din/dut_q; the checker owns the run status and error outputs.
interface ff_checker_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             din;
  logic             dut_q;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] fail_cycle;

  modport master (
    output start, din, dut_q,
    input  busy, done, pass, fail, err_count, fail_cycle
  );

  modport slave (
    input  start, din, dut_q,
    output busy, done, pass, fail, err_count, fail_cycle
  );
endinterface

// File: rtl/ff_checker.sv
// Compares a flop-based DUT output against a LATENCY-deep golden delay line of din.
// Optional macro FF_CHECKER_STOP_ON_FAIL_EN ends a run on its first mismatch.
module ff_checker #(
  parameter int LATENCY    = 1,
  parameter int NUM_CYCLES = 10000,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  ff_checker_if.slave  chk
);

  localparam int CYC_W  = 16;
  localparam int WCNT_W = $clog2(LATENCY + 1);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(NUM_CYCLES - 1);

`ifdef FF_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WARMUP, CHECK, DONE} state_t;

  state_t              state_q;
  logic [LATENCY-1:0]  sr_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [CYC_W-1:0]    cyc_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic                fail_q;
  logic [CNT_W-1:0]    err_count_q;
  logic [CNT_W-1:0]    fail_cycle_q;

  logic [LATENCY:0]    sr_ext;
  logic                expected;
  logic                mismatch;
  logic                fail_d;
  logic [CNT_W-1:0]    err_count_d;

  // Widening by one bit lets the same shift expression serve LATENCY == 1.
  assign sr_ext   = {sr_q, chk.din};
  assign expected = sr_q[LATENCY-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    mismatch    = 1'b0;
    fail_d      = fail_q;
    err_count_d = err_count_q;
    // Case inequality so that X/Z on dut_q is treated as a mismatch.
    mismatch    = (chk.dut_q !== expected);
    fail_d      = fail_q | mismatch;
    err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the golden delay line is reset too, so expected is known right after reset.
      state_q      <= IDLE;
      sr_q         <= '0;
      wcnt_q       <= '0;
      cyc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      err_count_q  <= '0;
      fail_cycle_q <= '0;
    end else begin
      sr_q   <= sr_ext[LATENCY-1:0];
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (chk.start) begin
            state_q      <= WARMUP;
            busy_q       <= 1'b1;
            wcnt_q       <= WCNT_W'(LATENCY);
            err_count_q  <= '0;
            fail_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_cycle_q <= '0;
          end
        end
        WARMUP: begin
          wcnt_q <= wcnt_q - 1'b1;
          if (wcnt_q == WCNT_W'(1)) begin
            state_q <= CHECK;
            cyc_q   <= '0;
          end
        end
        CHECK: begin
          cyc_q <= cyc_q + 1'b1;
          if (mismatch) begin
            err_count_q <= err_count_d;
            if (!fail_q) begin
              fail_q       <= 1'b1;
              fail_cycle_q <= CNT_W'(cyc_q);
            end
          end
          // The final cycle's compare result already feeds pass through fail_d.
          if (cyc_q == LAST_CYC || (STOP_ON_FAIL && mismatch)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= ~fail_d;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chk.busy       = busy_q;
  assign chk.done       = done_q;
  assign chk.pass       = pass_q;
  assign chk.fail       = fail_q;
  assign chk.err_count  = err_count_q;
  assign chk.fail_cycle = fail_cycle_q;

endmodule
